sync_filter_bank: RTL and testbench
===================================

Name: sync_filter_bank

Overview:
- Parametrised multi-channel synchroniser for bringing quasi-static or slow control bits into the local `sclk` domain.
- Successor to the fixed 2-flop, 3-bit synchroniser.
- Adds configurable stage count, configurable reset value, an optional per-channel stability (glitch) filter, and per-channel rise/fall pulse outputs.
- Sits on the destination side of ASYN_FIFO control/status crossings and crossbar sideband signals.

Parameters:
- DATA_SIZE, 3, number of independent single-bit channels (>=1).
- STAGES, 2, synchroniser flops per channel (>=2; elaboration error if <2).
- FILTER_LEN, 0, consecutive cycles a changed synchronised value must hold before `data_out` updates. 0 = filter bypassed.
- RESET_VAL, 0 (DATA_SIZE bits), reset value of every sync flop and of `data_out`.

Ports:
- sclk  input  1  destination clock; all state on posedge.
- srst_n  input  1  asynchronous, active-low reset.
- data_in  input  DATA_SIZE  asynchronous input bits, one per channel.
- data_out  output  DATA_SIZE  synchronised, filtered level per channel.
- rise_pulse  output  DATA_SIZE  one-cycle pulse per channel on a data_out 0->1 transition.
- fall_pulse  output  DATA_SIZE  one-cycle pulse per channel on a data_out 1->0 transition.
- changed  output  1  OR-reduction of rise_pulse | fall_pulse.

Behaviour:
- Reset: srst_n=0 immediately (asynchronously) forces:
  - all sync stages, data_out and the internal data_out_d register to RESET_VAL;
  - all filter counters to 0;
  - rise_pulse, fall_pulse and changed to 0.
- Deassertion is taken at posedge sclk; the first update happens on the first edge with srst_n=1.
- Sync chain, per channel: stage[0] <= data_in[i]; stage[k] <= stage[k-1]; sync_q = stage[STAGES-1].
  - A data_in value stable before edge 1 appears on sync_q after edge STAGES.
- FILTER_LEN=0: data_out = sync_q (no extra register). Latency = STAGES edges.
- FILTER_LEN=F>0: per-channel counter, width clog2(F+1). Each edge:
  - sync_q[i] == data_out[i]: cnt <= 0.
  - sync_q[i] != data_out[i] and cnt == F-1: data_out[i] <= sync_q[i]; cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - Latency = STAGES+F edges.
  - A sync_q excursion lasting fewer than F cycles never reaches data_out; the counter restarts from 0 at the next excursion.
- Channels are fully independent; simultaneous changes on several channels are handled in parallel.
- No inter-bit coherency is guaranteed; multi-bit buses must be gray-coded or qualified upstream.
- Edge detection: data_out_d <= data_out every edge.
  - rise_pulse = data_out & ~data_out_d; fall_pulse = ~data_out & data_out_d.
  - Pulses are high for exactly the first cycle data_out shows the new value.
- changed = |(rise_pulse | fall_pulse).
- No pulse is ever generated by reset entry or exit, whatever RESET_VAL is, because data_out_d is reset to RESET_VAL.
- Toggle faster than the latency with F=0: data_out follows sync_q exactly; each transition gives its own pulse.
- Back-to-back opposite transitions on consecutive cycles give a rise then a fall pulse on adjacent cycles.
- Reset mid-filter-count: the count is discarded; after release a full F-cycle hold is required again.

Test Plan:
- Reset: DATA_SIZE=3, RESET_VAL=0, srst_n=0 with data_in=3'b101, asserted between clock edges -> data_out=000 and all pulses 0 immediately. After release with data_in=000, no pulse for 10 cycles.
- STAGES=2, F=0: data_in 000->001 before edge 1 -> data_out=001 after edge 2; rise_pulse=001 and changed=1 for exactly one cycle; fall_pulse=000.
- STAGES=2, F=3: data_in[1] high held -> data_out[1]=1 after edge 5, rise_pulse[1] for one cycle. Then a 2-cycle low glitch on data_in[1] -> data_out stays 1 and no fall_pulse.
- STAGES=3, F=0, data_out=111: data_in->010 -> data_out=010 after edge 3; fall_pulse=101 for one cycle; rise_pulse=000.
- F=4: data_in[0] high, srst_n pulsed low after 2 of the 4 filter cycles -> data_out[0]=0 at once. After release, data_out[0]=1 only at edge STAGES+4 counted from release.
- RESET_VAL=3'b111, data_in=111 across reset entry/exit -> data_out=111 throughout; no rise or fall pulse; changed stays 0.

Source files
------------

// File: rtl/sync_filter_bank.sv
// sync_filter_bank
//   Multi-channel synchroniser that brings quasi-static or slow control bits
//   into the sclk domain. Each channel has a STAGES-deep flop chain, an
//   optional stability filter (FILTER_LEN > 0), and rise/fall pulse outputs.
//
// Ports
//   sclk        destination clock, all state on posedge
//   srst_n      asynchronous active-low reset
//   data_in     asynchronous input bits, one per channel
//   data_out    synchronised (and filtered) level per channel
//   rise_pulse  one-cycle pulse on a data_out 0->1 transition
//   fall_pulse  one-cycle pulse on a data_out 1->0 transition
//   changed     OR of all rise/fall pulses
//
// Channels are independent; no coherency between bits is provided, so
// multi-bit buses must be gray-coded or qualified upstream.

module sync_filter_bank #(
    parameter int                   DATA_SIZE  = 3,
    parameter int                   STAGES     = 2,
    parameter int                   FILTER_LEN = 0,
    parameter logic [DATA_SIZE-1:0] RESET_VAL  = '0
) (
    input  logic                 sclk,
    input  logic                 srst_n,
    input  logic [DATA_SIZE-1:0] data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [DATA_SIZE-1:0] rise_pulse,
    output logic [DATA_SIZE-1:0] fall_pulse,
    output logic                 changed
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_filter_bank: STAGES must be at least 2");
    end

    logic [DATA_SIZE-1:0] stage [STAGES];
    logic [DATA_SIZE-1:0] sync_q;
    logic [DATA_SIZE-1:0] data_out_d;

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= RESET_VAL;
            end
        end else begin
            stage[0] <= data_in;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign sync_q = stage[STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_bypass
            assign data_out = sync_q;
        end else begin : g_filter
            localparam int              CNT_W    = $clog2(FILTER_LEN + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

            logic [CNT_W-1:0]     cnt [DATA_SIZE];
            logic [DATA_SIZE-1:0] filt_q;

            // The counter runs only while sync_q disagrees with the filtered
            // level; any return to agreement restarts the hold from zero.
            always_ff @(posedge sclk or negedge srst_n) begin
                if (!srst_n) begin
                    filt_q <= RESET_VAL;
                    for (int i = 0; i < DATA_SIZE; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < DATA_SIZE; i++) begin
                        if (sync_q[i] == filt_q[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            filt_q[i] <= sync_q[i];
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
            end

            assign data_out = filt_q;
        end
    endgenerate

    // data_out_d resets to RESET_VAL so reset entry/exit never looks like an edge.
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            data_out_d <= RESET_VAL;
        end else begin
            data_out_d <= data_out;
        end
    end

    assign rise_pulse = data_out & ~data_out_d;
    assign fall_pulse = ~data_out & data_out_d;
    assign changed    = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_sync_filter_bank.sv
// Testbench for sync_filter_bank. Four instances with different STAGES,
// FILTER_LEN and RESET_VAL share one stimulus stream. A history-based
// reference model predicts every instance's outputs; predictions are queued
// by the stimulus process and checked by a separate monitor on the falling
// clock edge.

module tb_sync_filter_bank;

    localparam int ND = 4;

    logic       clk;
    logic       srst_n;
    logic [2:0] data_in;

    logic [2:0] dout_w [ND];
    logic [2:0] rise_w [ND];
    logic [2:0] fall_w [ND];
    logic [ND-1:0] chg_w;

    int         S_P  [ND] = '{2, 2, 3, 3};
    int         F_P  [ND] = '{0, 3, 4, 0};
    logic [2:0] RV_P [ND] = '{3'b000, 3'b000, 3'b111, 3'b101};

    sync_filter_bank #(.DATA_SIZE(3), .STAGES(2), .FILTER_LEN(0), .RESET_VAL(3'b000)) u_d0 (
        .sclk(clk), .srst_n(srst_n), .data_in(data_in), .data_out(dout_w[0]),
        .rise_pulse(rise_w[0]), .fall_pulse(fall_w[0]), .changed(chg_w[0]));
    sync_filter_bank #(.DATA_SIZE(3), .STAGES(2), .FILTER_LEN(3), .RESET_VAL(3'b000)) u_d1 (
        .sclk(clk), .srst_n(srst_n), .data_in(data_in), .data_out(dout_w[1]),
        .rise_pulse(rise_w[1]), .fall_pulse(fall_w[1]), .changed(chg_w[1]));
    sync_filter_bank #(.DATA_SIZE(3), .STAGES(3), .FILTER_LEN(4), .RESET_VAL(3'b111)) u_d2 (
        .sclk(clk), .srst_n(srst_n), .data_in(data_in), .data_out(dout_w[2]),
        .rise_pulse(rise_w[2]), .fall_pulse(fall_w[2]), .changed(chg_w[2]));
    sync_filter_bank #(.DATA_SIZE(3), .STAGES(3), .FILTER_LEN(0), .RESET_VAL(3'b101)) u_d3 (
        .sclk(clk), .srst_n(srst_n), .data_in(data_in), .data_out(dout_w[3]),
        .rise_pulse(rise_w[3]), .fall_pulse(fall_w[3]), .changed(chg_w[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] d [ND];
        logic [2:0] r [ND];
        logic [2:0] f [ND];
        logic       c [ND];
    } exp_t;

    exp_t sb [$];

    int tests;
    int fails;

    // Reference model: hist[k][j] is data_in as sampled on edge j+1 after
    // reset release. The synchronised value after edge m is the input taken
    // STAGES edges earlier. A filtered bit flips at edge n when the F
    // synchronised values seen on edges n-F+1..n all disagree with it and
    // none of those edges lies at or before its previous flip.
    logic [2:0] hist [ND][$];
    logic [2:0] m_out   [ND];
    logic [2:0] m_out_d [ND];
    int         last_upd [ND][3];

    function automatic logic sync_at(input int k, input int m, input int b);
        logic [2:0] v;
        if (m >= S_P[k]) v = hist[k][m - S_P[k]];
        else             v = RV_P[k];
        return v[b];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            hist[k].delete();
            m_out[k]   = RV_P[k];
            m_out_d[k] = RV_P[k];
            for (int b = 0; b < 3; b++) last_upd[k][b] = 0;
        end
    endtask

    task automatic model_edge(input logic [2:0] din);
        for (int k = 0; k < ND; k++) begin
            logic [2:0] prev;
            logic [2:0] nxt;
            int         n;
            hist[k].push_back(din);
            n    = hist[k].size();
            prev = m_out[k];
            nxt  = prev;
            for (int b = 0; b < 3; b++) begin
                if (F_P[k] == 0) begin
                    nxt[b] = sync_at(k, n, b);
                end else if (n - F_P[k] + 1 > last_upd[k][b]) begin
                    logic ok;
                    ok = 1'b1;
                    for (int j = 0; j < F_P[k]; j++) begin
                        if (sync_at(k, n - 1 - j, b) == prev[b]) ok = 1'b0;
                    end
                    if (ok) begin
                        nxt[b] = ~prev[b];
                        last_upd[k][b] = n;
                    end
                end
            end
            m_out_d[k] = prev;
            m_out[k]   = nxt;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        for (int k = 0; k < ND; k++) begin
            e.d[k] = m_out[k];
            e.r[k] = m_out[k] & ~m_out_d[k];
            e.f[k] = ~m_out[k] & m_out_d[k];
            e.c[k] = |(e.r[k] | e.f[k]);
        end
        sb.push_back(e);
    endtask

    // One cycle: model the edge (if out of reset), then drive new inputs
    // between edges and queue what the DUTs should show before the next edge.
    task automatic apply(input logic [2:0] v, input logic r, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (srst_n) model_edge(data_in);
            #1;
            data_in = v;
            srst_n  = r;
            if (!r) model_reset();
            push_expect();
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [2:0] got, input logic [2:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s dut%0d at %0t: got %b expected %b", nm, k, $time, got, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < ND; k++) begin
                    chk("data_out",   k, dout_w[k], e.d[k]);
                    chk("rise_pulse", k, rise_w[k], e.r[k]);
                    chk("fall_pulse", k, fall_w[k], e.f[k]);
                    chk("changed",    k, {2'b00, chg_w[k]}, {2'b00, e.c[k]});
                end
            end
        end
    end

    initial begin : stimulus
        logic [2:0] cur;
        logic [2:0] g;
        tests   = 0;
        fails   = 0;
        srst_n  = 1'b0;
        data_in = 3'b000;
        model_reset();

        apply(3'b000, 1'b0, 3);
        apply(3'b000, 1'b1, 6);
        // reset asserted between edges with data_in=101, then released with 000
        apply(3'b101, 1'b0, 2);
        apply(3'b000, 1'b1, 12);
        // single rise on channel 0
        apply(3'b001, 1'b1, 8);
        apply(3'b000, 1'b1, 8);
        // channel 1 held high, then a 2-cycle low glitch
        apply(3'b010, 1'b1, 10);
        apply(3'b000, 1'b1, 2);
        apply(3'b010, 1'b1, 10);
        // all high, then 010 for a two-bit fall
        apply(3'b111, 1'b1, 12);
        apply(3'b010, 1'b1, 10);
        // reset in the middle of a filter count
        apply(3'b000, 1'b1, 12);
        apply(3'b001, 1'b1, 5);
        apply(3'b001, 1'b0, 1);
        apply(3'b001, 1'b1, 14);
        // all-ones held across reset entry and exit
        apply(3'b111, 1'b1, 12);
        apply(3'b111, 1'b0, 3);
        apply(3'b111, 1'b1, 12);
        // fast toggling on one channel
        for (int i = 0; i < 8; i++) apply((i % 2) ? 3'b100 : 3'b000, 1'b1, 1);
        apply(3'b000, 1'b1, 10);

        cur = 3'b000;
        for (int i = 0; i < 1200; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                apply(cur, 1'b0, $urandom_range(1, 3));
            end else if (r < 40) begin
                cur = 3'($urandom_range(0, 7));
                apply(cur, 1'b1, $urandom_range(1, 8));
            end else if (r < 60) begin
                g = cur;
                g[$urandom_range(0, 2)] = ~g[$urandom_range(0, 2)];
                apply(g, 1'b1, $urandom_range(1, 5));
                apply(cur, 1'b1, 1);
            end else begin
                apply(cur, 1'b1, $urandom_range(1, 6));
            end
        end
        apply(cur, 1'b1, 12);

        @(negedge clk);
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
